// File: rtl/pattern_generator.sv
// Reaction-game pattern source: divides the clock to the game tick and issues
// non-repeating LFSR target patterns with programmable hold and gap times.
module pattern_generator #(
   parameter int unsigned CLK_HZ    = 50_000_000,
   parameter int unsigned TICK_HZ   = 10,
   parameter logic [7:0]  LFSR_SEED = 8'hA5,
   parameter logic [7:0]  HOLD_RST  = 8'd20,
   parameter logic [7:0]  GAP_RST   = 8'd5
) (
   input  logic       CLOCK50M,
   input  logic       reset,
   input  logic       enable,
   input  logic       write,
   input  logic [1:0] address,
   input  logic [7:0] writedata,
   output logic [7:0] readdata,
   output logic       counter10h,
   output logic [7:0] pattern,
   output logic [7:0] round
);

   localparam int unsigned DIV = CLK_HZ / TICK_HZ;
   localparam int unsigned DW  = $clog2(DIV);
   localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

   typedef enum logic [1:0] {IDLE, SHOW, GAP} state_t;

   logic [DW-1:0] div_cnt_reg;
   logic          counter10h_reg;
   logic [7:0]    hold_reg;
   logic [7:0]    gap_reg;
   logic [7:0]    lfsr_reg;
   logic [7:0]    lfsr_next;
   state_t        state_reg;
   logic [7:0]    tcnt_reg;
   logic [7:0]    pattern_reg;
   logic [7:0]    round_reg;
   logic [7:0]    hold_eff;
   logic          tick;
   logic          issue;
   logic          seed_wr;

   always_comb begin
      tick      = (div_cnt_reg == DIV_LAST);
      hold_eff  = (hold_reg == 8'd0) ? 8'd1 : hold_reg;
      seed_wr   = write && (address == 2'd2);
      lfsr_next = {1'b0, lfsr_reg[7:1]} ^ (lfsr_reg[0] ? 8'hB8 : 8'h00);
      issue     = 1'b0;
      case (state_reg)
         IDLE:    issue = enable && tick;
         SHOW:    issue = enable && tick && (tcnt_reg == 8'd0) && (gap_reg == 8'd0);
         GAP:     issue = enable && tick && (tcnt_reg == 8'd0);
         default: issue = 1'b0;
      endcase
   end

   always_ff @(posedge CLOCK50M or posedge reset) begin
      if (reset) begin
         div_cnt_reg    <= '0;
         counter10h_reg <= 1'b0;
      end else begin
         div_cnt_reg    <= tick ? '0 : div_cnt_reg + DW'(1);
         counter10h_reg <= tick;
      end
   end

   always_ff @(posedge CLOCK50M or posedge reset) begin
      if (reset) begin
         hold_reg <= HOLD_RST;
         gap_reg  <= GAP_RST;
      end else if (write) begin
         if (address == 2'd0) hold_reg <= writedata;
         if (address == 2'd1) gap_reg  <= writedata;
      end
   end

   // A seed write on an issue edge overrides the advance; the issued pattern
   // still comes from the pre-write LFSR value.
   always_ff @(posedge CLOCK50M or posedge reset) begin
      if (reset)
         lfsr_reg <= LFSR_SEED;
      else if (seed_wr)
         lfsr_reg <= (writedata == 8'd0) ? LFSR_SEED : writedata;
      else if (issue)
         lfsr_reg <= lfsr_next;
   end

   always_ff @(posedge CLOCK50M or posedge reset) begin
      if (reset) begin
         state_reg   <= IDLE;
         tcnt_reg    <= 8'd0;
         pattern_reg <= 8'd0;
         round_reg   <= 8'd0;
      end else if (!enable) begin
         state_reg   <= IDLE;
         tcnt_reg    <= 8'd0;
         pattern_reg <= 8'd0;
      end else if (tick) begin
         if (issue) begin
            state_reg   <= SHOW;
            pattern_reg <= lfsr_reg;
            round_reg   <= round_reg + 8'd1;
            tcnt_reg    <= hold_eff - 8'd1;
         end else begin
            case (state_reg)
               SHOW: begin
                  if (tcnt_reg != 8'd0) begin
                     tcnt_reg <= tcnt_reg - 8'd1;
                  end else begin
                     state_reg   <= GAP;
                     pattern_reg <= 8'd0;
                     tcnt_reg    <= gap_reg - 8'd1;
                  end
               end
               GAP:     tcnt_reg <= tcnt_reg - 8'd1;
               default: tcnt_reg <= tcnt_reg;
            endcase
         end
      end
   end

   always_comb begin
      readdata = 8'd0;
      case (address)
         2'd0: readdata = hold_reg;
         2'd1: readdata = gap_reg;
         2'd2: readdata = lfsr_reg;
         2'd3: readdata = round_reg;
         default: readdata = 8'd0;
      endcase
   end

   assign counter10h = counter10h_reg;
   assign pattern    = pattern_reg;
   assign round      = round_reg;

endmodule

// File: tb/tb_pattern_generator.sv
// Bench for pattern_generator at DIV=10 against a tick-level arithmetic model.
module tb_pattern_generator;

   logic       CLOCK50M = 1'b0;
   logic       reset = 1'b1;
   logic       enable = 1'b0;
   logic       write = 1'b0;
   logic [1:0] address = 2'd0;
   logic [7:0] writedata = 8'd0;
   logic [7:0] readdata;
   logic       counter10h;
   logic [7:0] pattern;
   logic [7:0] round;

   int vectors = 0;
   int miscompares = 0;
   int k = 0;

   pattern_generator #(.CLK_HZ(100), .TICK_HZ(10)) dut (
      .CLOCK50M  (CLOCK50M),
      .reset     (reset),
      .enable    (enable),
      .write     (write),
      .address   (address),
      .writedata (writedata),
      .readdata  (readdata),
      .counter10h(counter10h),
      .pattern   (pattern),
      .round     (round)
   );

   always #5 CLOCK50M = ~CLOCK50M;

   function automatic logic [7:0] lfsr_adv(input logic [7:0] l);
      return (l >> 1) ^ (l[0] ? 8'hB8 : 8'h00);
   endfunction

   task automatic step();
      @(posedge CLOCK50M);
      #1;
      k++;
   endtask

   // Reset, then program hold/gap/seed on edges 1..3 and enable before the first tick.
   task automatic start_run(input logic [7:0] h, input logic [7:0] g, input logic [7:0] s);
      reset = 1'b1; enable = 1'b0; write = 1'b0;
      @(posedge CLOCK50M);
      #1;
      reset = 1'b0;
      k = 0;
      write = 1'b1;
      address = 2'd0; writedata = h; step();
      address = 2'd1; writedata = g; step();
      address = 2'd2; writedata = s; step();
      write = 1'b0;
      enable = 1'b1;
   endtask

   // Expected outputs at edge k follow from the tick index alone: each pattern
   // occupies max(hold,1) ticks followed by gap ticks of zero.
   task automatic run_model(input string name, input logic [7:0] h, input logic [7:0] g,
                            input logic [7:0] s, input int ncyc);
      logic [7:0] seq [0:399];
      logic [7:0] exp_pat, exp_rnd, exp_lf, exp_rd;
      logic       exp_tick;
      int n, j, o, hh, per;
      seq[0] = (s == 8'd0) ? 8'hA5 : s;
      for (int i = 1; i < 400; i++) seq[i] = lfsr_adv(seq[i-1]);
      hh  = (h == 8'd0) ? 1 : int'(h);
      per = hh + int'(g);
      start_run(h, g, s);
      for (int c = 0; c < ncyc; c++) begin
         step();
         n = k / 10;
         exp_tick = (k % 10 == 0);
         if (n == 0) begin
            exp_pat = 8'd0; exp_rnd = 8'd0; exp_lf = seq[0];
         end else begin
            j = (n - 1) / per;
            o = (n - 1) % per;
            exp_pat = (o < hh) ? seq[j] : 8'd0;
            exp_rnd = 8'((j + 1) % 256);
            exp_lf  = seq[j+1];
         end
         address = 2'($urandom_range(0, 3));
         case (address)
            2'd0: exp_rd = h;
            2'd1: exp_rd = g;
            2'd2: exp_rd = exp_lf;
            default: exp_rd = exp_rnd;
         endcase
         #1;
         vectors++;
         if (pattern !== exp_pat || round !== exp_rnd || counter10h !== exp_tick || readdata !== exp_rd) begin
            miscompares++;
            $display("FAIL %s edge %0d: got pat=%h rnd=%h tick=%b rd[%0d]=%h, expected pat=%h rnd=%h tick=%b rd=%h",
                     name, k, pattern, round, counter10h, address, readdata, exp_pat, exp_rnd, exp_tick, exp_rd);
         end
      end
      $display("%s: hold=%0d gap=%0d seed=%h, %0d cycles checked", name, h, g, s, ncyc);
   endtask

   task automatic test_reset();
      logic [7:0] exp_rd [0:3];
      exp_rd[0] = 8'd20; exp_rd[1] = 8'd5; exp_rd[2] = 8'hA5; exp_rd[3] = 8'd0;
      reset = 1'b1; enable = 1'b0; write = 1'b0;
      @(posedge CLOCK50M);
      @(posedge CLOCK50M);
      #1;
      reset = 1'b0;
      #1;
      vectors++;
      if (pattern !== 8'd0 || round !== 8'd0 || counter10h !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_outputs: got pat=%h rnd=%h tick=%b, expected 00 00 0", pattern, round, counter10h);
      end
      for (int a = 0; a < 4; a++) begin
         address = 2'(a);
         #1;
         vectors++;
         if (readdata !== exp_rd[a]) begin
            miscompares++;
            $display("FAIL reset_readdata[%0d]: got %h, expected %h", a, readdata, exp_rd[a]);
         end
      end
      $display("test_reset done");
   endtask

   task automatic test_tick();
      reset = 1'b1; enable = 1'b0;
      @(posedge CLOCK50M);
      #1;
      reset = 1'b0;
      k = 0;
      for (int c = 0; c < 100; c++) begin
         step();
         vectors++;
         if (counter10h !== (k % 10 == 0) || pattern !== 8'd0) begin
            miscompares++;
            $display("FAIL tick edge %0d: got tick=%b pat=%h, expected tick=%b pat=00",
                     k, counter10h, pattern, (k % 10 == 0));
         end
      end
      $display("test_tick done");
   endtask

   task automatic test_sequence();
      run_model("sequence", 8'd20, 8'd5, 8'hA5, 270);
   endtask

   task automatic test_zero_hold_gap();
      run_model("zero_hold_gap", 8'd0, 8'd0, 8'hA5, 2600);
   endtask

   task automatic test_seed();
      run_model("seed01", 8'd1, 8'd1, 8'h01, 50);
      start_run(8'd20, 8'd5, 8'h00);
      address = 2'd2;
      #1;
      vectors++;
      if (readdata !== 8'hA5) begin
         miscompares++;
         $display("FAIL seed_zero_readback: got %h, expected a5", readdata);
      end
      // Seed write lands on the same edge as a tick-driven issue.
      start_run(8'd0, 8'd0, 8'hA5);
      while (k < 19) step();
      write = 1'b1; address = 2'd2; writedata = 8'h33;
      step();
      write = 1'b0;
      #1;
      vectors++;
      if (pattern !== 8'hEA || round !== 8'd2 || readdata !== 8'h33) begin
         miscompares++;
         $display("FAIL seed_on_tick: got pat=%h rnd=%h lfsr=%h, expected pat=ea rnd=02 lfsr=33",
                  pattern, round, readdata);
      end
      while (k < 30) step();
      vectors++;
      if (pattern !== 8'h33 || round !== 8'd3) begin
         miscompares++;
         $display("FAIL seed_after_tick: got pat=%h rnd=%h, expected pat=33 rnd=03", pattern, round);
      end
      $display("test_seed done");
   endtask

   task automatic test_random();
      for (int it = 0; it < 6; it++)
         run_model($sformatf("random%0d", it), 8'($urandom_range(0, 4)), 8'($urandom_range(0, 3)),
                   8'($urandom_range(0, 255)), 250);
   endtask

   task automatic test_disable();
      start_run(8'd20, 8'd5, 8'hA5);
      while (k < 50) step();
      vectors++;
      if (pattern !== 8'hA5 || round !== 8'd1) begin
         miscompares++;
         $display("FAIL disable_pre: got pat=%h rnd=%h, expected a5 01", pattern, round);
      end
      enable = 1'b0;
      step();
      vectors++;
      if (pattern !== 8'd0 || round !== 8'd1) begin
         miscompares++;
         $display("FAIL disable_edge: got pat=%h rnd=%h, expected 00 01", pattern, round);
      end
      while (k < 60) step();
      address = 2'd2;
      #1;
      vectors++;
      if (counter10h !== 1'b1 || pattern !== 8'd0 || round !== 8'd1 || readdata !== 8'hEA) begin
         miscompares++;
         $display("FAIL disable_hold: got tick=%b pat=%h rnd=%h lfsr=%h, expected 1 00 01 ea",
                  counter10h, pattern, round, readdata);
      end
      enable = 1'b1;
      while (k < 70) step();
      vectors++;
      if (pattern !== 8'hEA || round !== 8'd2) begin
         miscompares++;
         $display("FAIL disable_resume: got pat=%h rnd=%h, expected ea 02", pattern, round);
      end
      $display("test_disable done");
   endtask

   task automatic test_reset_mid_run();
      logic [7:0] exp_rd [0:3];
      int stop_at [0:1];
      exp_rd[0] = 8'd20; exp_rd[1] = 8'd5; exp_rd[2] = 8'hA5; exp_rd[3] = 8'd0;
      stop_at[0] = 30;   // inside SHOW
      stop_at[1] = 50;   // inside GAP
      for (int p = 0; p < 2; p++) begin
         start_run(8'd3, 8'd4, 8'h5C);
         while (k < stop_at[p]) step();
         reset = 1'b1;
         #1;
         vectors++;
         if (pattern !== 8'd0 || round !== 8'd0 || counter10h !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid_%0d: got pat=%h rnd=%h tick=%b, expected 00 00 0",
                     stop_at[p], pattern, round, counter10h);
         end
         for (int a = 0; a < 4; a++) begin
            address = 2'(a);
            #1;
            vectors++;
            if (readdata !== exp_rd[a]) begin
               miscompares++;
               $display("FAIL reset_mid_%0d_rd[%0d]: got %h, expected %h", stop_at[p], a, readdata, exp_rd[a]);
            end
         end
      end
      $display("test_reset_mid_run done");
   endtask

   initial begin
      test_reset();
      test_tick();
      test_sequence();
      test_zero_hold_gap();
      test_seed();
      test_random();
      test_disable();
      test_reset_mid_run();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/pattern_generator.md
# pattern_generator

Source side of the reaction game. It divides CLOCK50M down to the 10 Hz game tick (`counter10h`) and drives a stream of non-zero, never-repeating 8-bit target patterns into the score calculator's `pattern`/`counter10h` inputs. Each pattern is held for a programmable number of ticks, then followed by a programmable all-zero gap. Hold, gap and seed are set through a small 2-bit-address register port on the same bus style as the scorer.

## Interface
- `CLK_HZ`, 50_000_000: input clock frequency.
- `TICK_HZ`, 10: tick rate. `DIV = CLK_HZ/TICK_HZ` must be ≥ 2.
- `LFSR_SEED`, 8'hA5: LFSR reset value. Must be non-zero.
- `HOLD_RST`, 8'd20: reset value of the hold register.
- `GAP_RST`, 8'd5: reset value of the gap register.

Ports:
- `CLOCK50M`  in  1: clock, rising edge.
- `reset`  in  1: asynchronous, active-high.
- `enable`  in  1: run game; level.
- `write`  in  1: register write strobe, one cycle.
- `address`  in  2: register select.
- `writedata`  in  8: write data.
- `readdata`  out  8: combinational read of the register at `address`.
- `counter10h`  out  1: registered tick pulse, one cycle wide.
- `pattern`  out  8: registered target pattern; 0 means no target.
- `round`  out  8: number of patterns issued; wraps.

## Operation
- Register map:
  - 0 = hold (R/W).
  - 1 = gap (R/W).
  - 2 = seed. Write loads the LFSR with `writedata`, or with `LFSR_SEED` if `writedata` is 0. Read returns the current LFSR.
  - 3 = round (read-only; writes ignored).
- Divider `div_cnt`:
  - Counts 0..DIV-1 and wraps.
  - `tick` is asserted when `div_cnt == DIV-1`.
  - `counter10h` is registered: it goes high at the edge where `tick` is true and is high for exactly one cycle.
- LFSR: 8-bit Galois, right shift. Next value = `(l>>1) ^ (l[0] ? 8'hB8 : 0)`. This is maximal length (255), so it never reaches 0 and never repeats within 255 steps.
- FSM states: IDLE, SHOW, GAP. All transitions happen only on `tick` edges, except the disable rule below.
  - **IDLE:** `pattern`=0. On `tick` with `enable`=1:
    - `pattern`<=LFSR.
    - LFSR advances.
    - `round`+=1.
    - `tcnt`<=max(hold,1)-1.
    - Go to SHOW.
  - **SHOW:** on `tick`:
    - If `tcnt`≠0, decrement `tcnt`.
    - Otherwise, if gap≠0: `pattern`<=0, `tcnt`<=gap-1, go to GAP.
    - Otherwise (gap=0): issue the next pattern immediately, exactly as from IDLE, and stay in SHOW.
  - **GAP:** on `tick`:
    - If `tcnt`≠0, decrement `tcnt`.
    - Otherwise issue the next pattern, as from IDLE, and go to SHOW.
- `enable`=0 in any state: at the next clock edge (not tick-gated), go to IDLE, `pattern`<=0, `tcnt`<=0. The divider, LFSR and `round` keep their values.
- Hold/gap writes take effect at the next load of `tcnt`. A pattern already in progress is not shortened or lengthened.
- Seed write on the same edge as a pattern issue:
  - The issued pattern uses the pre-write LFSR value.
  - The LFSR takes the written seed; the seed write wins over the advance.
- `round` is 8-bit and wraps 255→0.

## Timing
- Reset values:
  - `pattern`=0, `counter10h`=0, `round`=0.
  - LFSR=`LFSR_SEED`, hold=`HOLD_RST`, gap=`GAP_RST`.
  - `div_cnt`=0, state IDLE.
  - `readdata` follows `address` against these values.
- First `counter10h` pulse is high in cycle DIV after reset release. Pulses are then every DIV cycles.
- `pattern` updates at the same edge that raises `counter10h`. A downstream block sampling on `counter10h` therefore sees the new value in that cycle.
- Pattern duration is exactly max(hold,1)×DIV cycles; gap duration is exactly gap×DIV cycles.
- A write is visible on `readdata` the cycle after the `write` edge.
- Reset asserted mid-SHOW or mid-GAP takes effect immediately (asynchronous) and clears everything to the reset values.

## Test plan
Benches use `CLK_HZ`=100, `TICK_HZ`=10 (DIV=10), with default hold/gap unless stated.
- Reset: pulse `reset` → `pattern`=0, `round`=0, `counter10h`=0. `readdata` returns 20, 5, 0xA5, 0 for addresses 0..3.
- Tick: `enable`=0, run 100 cycles → `counter10h` is high for 1 cycle at cycles 10, 20, …, 100. `pattern` stays 0.
- Sequence: `enable`=1 → `pattern`=0xA5 from tick 1 through tick 20 (200 cycles), then 0 for 50 cycles, then 0xEA. `round`=2.
- Zero hold/gap: write hold=0, gap=0 → a new pattern on every tick: 0xA5, 0xEA, 0x75, … All values non-zero and consecutive values differ.
- Seed:
  - Write seed 0x01 → next two patterns are 0x01, then 0xB8.
  - Write seed 0 → readback shows 0xA5.
  - Seed write coincident with a tick → issued pattern is the old LFSR value.
- Disable/reset mid-run:
  - Drop `enable` during SHOW → `pattern`=0 on the next edge; `round` is unchanged.
  - Assert `reset` mid-GAP → all outputs and registers return to reset values immediately.
